// File: rtl/reset_sequencer.sv
// Ordered release of downstream reset domains with settle delay and ready handshake.
// Optional ready timeout with sticky error flag: define RESET_SEQ_TIMEOUT_EN.
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int STAGE_DELAY_CC = 1000,
    parameter int TIMEOUT_CC     = 65536
) (
    input  logic                   piul1Clock,
    input  logic                   piul1ResetN,
    input  logic                   piul1SeqReset,
    input  logic [NUM_DOMAINS-1:0] piulvReady,
    output logic [NUM_DOMAINS-1:0] poulvResetN,
    output logic                   poul1Done,
    output logic                   poul1Error,
    output logic [3:0]             poulvStage
);

    localparam int MAX_CC = (STAGE_DELAY_CC > TIMEOUT_CC) ? STAGE_DELAY_CC : TIMEOUT_CC;
    localparam int CW     = $clog2(MAX_CC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_WAIT_READY,
        S_RUN,
        S_SHUTDOWN
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [3:0]             stage_q, stage_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [NUM_DOMAINS-1:0] stage_oh;
    logic                   ready_cur;
    logic                   last_stage;

    assign stage_oh   = NUM_DOMAINS'(1) << stage_q;
    assign ready_cur  = |(piulvReady & stage_oh);
    assign last_stage = (stage_q == 4'(NUM_DOMAINS - 1));

    // Next-state and next-output logic for the sequencing FSM
    always_comb begin
        state_d = state_q;
        rst_d   = rst_q;
        done_d  = done_q;
        err_d   = err_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
`ifdef RESET_SEQ_TIMEOUT_EN
        if (piul1SeqReset) begin
            err_d = 1'b0;
        end
`endif
        unique case (state_q)
            S_IDLE: begin
                rst_d   = '0;
                done_d  = 1'b0;
                stage_d = 4'd0;
                cnt_d   = '0;
                if (!piul1SeqReset && !err_q) begin
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (piul1SeqReset) begin
                    cnt_d = '0;
                    // Nothing released yet at stage 0: skip the shutdown walk
                    if (stage_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        stage_d = stage_q - 4'd1;
                        state_d = S_SHUTDOWN;
                    end
                end else if (cnt_q == CW'(STAGE_DELAY_CC - 1)) begin
                    rst_d   = rst_q | stage_oh;
                    cnt_d   = '0;
                    state_d = S_WAIT_READY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_READY: begin
                if (piul1SeqReset) begin
                    cnt_d   = '0;
                    state_d = S_SHUTDOWN;
                end else if (ready_cur) begin
                    cnt_d = '0;
                    if (last_stage) begin
                        done_d  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        stage_d = stage_q + 4'd1;
                        state_d = S_DELAY;
                    end
                end
`ifdef RESET_SEQ_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CC - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHUTDOWN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_RUN: begin
                if (piul1SeqReset || !(&piulvReady)) begin
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHUTDOWN;
                end
            end
            S_SHUTDOWN: begin
                // stage_q always names the highest still-released domain here
                rst_d = rst_q & ~stage_oh;
                if (stage_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    stage_d = stage_q - 4'd1;
                end
            end
            default: begin
                rst_d   = '0;
                done_d  = 1'b0;
                stage_d = 4'd0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge piul1Clock or negedge piul1ResetN) begin
        if (!piul1ResetN) begin
            state_q <= S_IDLE;
            rst_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stage_q <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign poulvResetN = rst_q;
    assign poul1Done   = done_q;
    assign poul1Error  = err_q;
    assign poulvStage  = stage_q;

endmodule
